fft_addr_sequencer: RTL

FFT_ADDR_SEQUENCER -- requirements
Module: fft_addr_sequencer

---
 rtl/fft_addr_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fft_addr_sequencer.sv
// Radix-2 DIT FFT butterfly address / twiddle sequencer (bit-reversed input order).
// Ports: clk, rst (sync, active-high); start, abort, bf_ready in;
//        bf_valid, addr_a, addr_b, twiddle_idx, stage, last_in_stage, busy, done out.
module fft_addr_sequencer #(
    parameter int LOG2_N    = 10,
    parameter int STAGE_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              bf_ready,
    output logic              bf_valid,
    output logic [LOG2_N-1:0] addr_a,
    output logic [LOG2_N-1:0] addr_b,
    output logic [LOG2_N-2:0] twiddle_idx,
    output logic [3:0]        stage,
    output logic              last_in_stage,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    localparam logic [3:0]        LAST_STAGE = 4'(LOG2_N - 1);
    localparam logic [3:0]        GAP_LOAD   = 4'(STAGE_GAP - 1);
    localparam logic [LOG2_N-2:0] J_ONE      = (LOG2_N - 1)'(1);
    localparam logic [LOG2_N-1:0] N_ONE      = LOG2_N'(1);

    state_t            state_q, state_d;
    logic [3:0]        stage_q, stage_d;
    logic [LOG2_N-2:0] j_q, j_d;
    logic [3:0]        gap_q, gap_d;

    logic              run;
    logic              j_last;
    logic              stage_last;
    logic [LOG2_N-1:0] jx;
    logic [LOG2_N-1:0] lo_mask;
    logic [LOG2_N-1:0] lo;
    logic [LOG2_N-1:0] hi;
    logic [LOG2_N-1:0] a;
    logic [LOG2_N-1:0] half;
    logic [LOG2_N-2:0] tw;

    assign run        = (state_q == RUN);
    assign j_last     = (j_q == '1);
    assign stage_last = (stage_q == LAST_STAGE);

    // addr_a is j with a zero bit inserted at position stage;
    // addr_b sets that bit. The low bits below stage are the
    // position in the group, which scales into the twiddle index.
    always_comb begin
        jx      = {1'b0, j_q};
        lo_mask = ~({LOG2_N{1'b1}} << stage_q);
        lo      = jx & lo_mask;
        hi      = (jx & ~lo_mask) << 1;
        a       = hi | lo;
        half    = N_ONE << stage_q;
        tw      = lo[LOG2_N-2:0] << (LAST_STAGE - stage_q);
    end

    assign bf_valid      = run;
    assign addr_a        = run ? a : '0;
    assign addr_b        = run ? (a | half) : '0;
    assign twiddle_idx   = run ? tw : '0;
    assign last_in_stage = run & j_last;
    assign stage         = stage_q;
    assign busy          = (state_q == RUN) || (state_q == GAP);
    assign done          = (state_q == FIN);

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    stage_d = '0;
                    j_d     = '0;
                end else if (bf_ready) begin
                    if (!j_last) begin
                        j_d = j_q + J_ONE;
                    end else begin
                        j_d = '0;
                        if (stage_last) begin
                            state_d = FIN;
                            stage_d = '0;
                        end else if (STAGE_GAP == 0) begin
                            stage_d = stage_q + 4'd1;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    stage_d = '0;
                    j_d     = '0;
                end else if (gap_q == 4'd0) begin
                    state_d = RUN;
                    stage_d = stage_q + 4'd1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
                stage_d = '0;
                j_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            j_q     <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            gap_q   <= gap_d;
        end
    end

endmodule
